// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a five-stage in-order pipeline.
// Tracks destination tags in EX, MEM and WB. Selects the forwarding source for
// each decode operand. Stalls decode on a load-use hazard or while the load in
// MEM waits for its data.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | last cycle advanced normally
// LOADUSE  | last cycle inserted one bubble behind a load in EX
// MEMWAIT  | last cycle froze EX/MEM while the MEM load waited for data
module hazard_scoreboard #(
    parameter     NAME  = "HSB",
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IssueValid,
    input  logic [4:0]       IssueRs,
    input  logic [4:0]       IssueRt,
    input  logic             UsesRs,
    input  logic             UsesRt,
    input  logic [4:0]       IssueDest,
    input  logic             IssueWrites,
    input  logic             IssueIsLoad,
    input  logic             MemReady,
    output logic             Stall,
    output logic [1:0]       FwdSel1,
    output logic [1:0]       FwdSel2,
    output logic             WbValid,
    output logic [4:0]       WbDest,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCycles
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       writes;
        logic       load;
    } tag_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOADUSE = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    tag_t             ex_q, ex_d;
    tag_t             mem_q, mem_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_dest_q, wb_dest_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic load_use, mem_stall, stall;
    tag_t issue_tag;

    // A stage feeds a source only if it really writes that non-zero register
    // and the decoding instruction really reads it.
    function automatic logic src_match(input tag_t t, input logic [4:0] r, input logic uses);
        return t.valid & t.writes & (t.dest == r) & (r != 5'd0) & uses;
    endfunction

    // A load in EX has no data yet, so an EX match only forwards for non-loads;
    // a load in MEM forwards whenever it is not stalling the pipe.
    function automatic logic [1:0] fwd_pick(input logic ex_m, input logic ex_load, input logic mem_m);
        if (ex_m && !ex_load) begin
            return FWD_EX;
        end else if (mem_m) begin
            return FWD_MEM;
        end
        return FWD_RF;
    endfunction

    // Hazard detection and forwarding selection, zero-latency from the inputs.
    always_comb begin
        ex_rs     = src_match(ex_q,  IssueRs, UsesRs);
        ex_rt     = src_match(ex_q,  IssueRt, UsesRt);
        mem_rs    = src_match(mem_q, IssueRs, UsesRs);
        mem_rt    = src_match(mem_q, IssueRt, UsesRt);
        load_use  = IssueValid & (ex_rs | ex_rt) & ex_q.load;
        mem_stall = mem_q.valid & mem_q.load & ~MemReady;
        stall     = load_use | mem_stall;
        FwdSel1   = fwd_pick(ex_rs, ex_q.load, mem_rs);
        FwdSel2   = fwd_pick(ex_rt, ex_q.load, mem_rt);
    end

    // Pipeline tag movement and state selection; a memory wait outranks load-use.
    always_comb begin
        issue_tag = '0;
        if (IssueValid) begin
            issue_tag = '{valid: 1'b1, dest: IssueDest, writes: IssueWrites, load: IssueIsLoad};
        end
        ex_d       = issue_tag;
        mem_d      = ex_q;
        wb_valid_d = mem_q.valid;
        wb_dest_d  = mem_q.dest;
        state_d    = ST_RUN;
        if (mem_stall) begin
            ex_d       = ex_q;
            mem_d      = mem_q;
            wb_valid_d = 1'b0;
            wb_dest_d  = 5'd0;
            state_d    = ST_MEMWAIT;
        end else if (load_use) begin
            ex_d    = '0;
            state_d = ST_LOADUSE;
        end
    end

    // Stall-cycle counter holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= 5'd0;
            state_q    <= ST_RUN;
            cnt_q      <= '0;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    // Simulation sanity check: encoding 3 is reserved on the forwarding selects.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            assert ((FwdSel1 != 2'd3) && (FwdSel2 != 2'd3))
                else $error("%s: reserved forwarding select driven", NAME);
        end
    end

    assign Stall       = stall;
    assign WbValid     = wb_valid_q;
    assign WbDest      = wb_dest_q;
    assign State       = state_q;
    assign StallCycles = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NAME, default "HSB", instance tag used in simulation messages.
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IssueValid  input  1  decode stage presents an instruction.
REQ-006 SHALL have ports IssueRs, IssueRt  input  5 each  source register numbers.
REQ-007 SHALL have ports UsesRs, UsesRt  input  1 each  the source is actually read.
REQ-008 SHALL have port IssueDest  input  5  destination register number.
REQ-009 SHALL have port IssueWrites  input  1  the instruction writes IssueDest.
REQ-010 SHALL have port IssueIsLoad  input  1  the instruction is a memory load.
REQ-011 SHALL have port MemReady  input  1  load data is available this cycle for the load in MEM.
REQ-012 SHALL have port Stall  output  1  decode must hold; the issue is not accepted.
REQ-013 SHALL have ports FwdSel1, FwdSel2  output  2 each  operand source for Rs and Rt: 0 = register file, 1 = 1st-priority (EX result), 2 = 2nd-priority (MEM result); 3 is never driven.
REQ-014 SHALL have ports WbValid (output, 1) and WbDest (output, 5)  registered writeback-stage tag.
REQ-015 SHALL have port State  output  2  0 RUN, 1 LOADUSE, 2 MEMWAIT.
REQ-016 SHALL have port StallCycles  output  CNT_W  saturating count of stalled cycles.

Function
REQ-017 SHALL keep tag registers EX, MEM and WB, each holding {valid, dest, writes, load}.
REQ-018 SHALL treat a stage as matching source r only if valid & writes & dest==r & r!=0 & the corresponding Uses bit is set.
REQ-019 SHALL drive LoadUse combinationally as IssueValid & (EX matches Rs or Rt) & EX.load.
REQ-020 SHALL drive MemStall combinationally as MEM.valid & MEM.load & !MemReady.
REQ-021 SHALL drive Stall = LoadUse | MemStall, with zero-cycle latency from the inputs.
REQ-022 SHALL set FwdSel = 1 on an EX match with EX.load = 0; otherwise 2 on a MEM match; otherwise 0. EX has priority over MEM when both match.
REQ-023 When Stall=0, the next cycle SHALL be EX <= issued tag (bubble if IssueValid=0), MEM <= EX, WB <= MEM.
REQ-024 When LoadUse=1 and MemStall=0, the next cycle SHALL be EX <= bubble, MEM <= EX, WB <= MEM (exactly one bubble).
REQ-025 When MemStall=1, EX and MEM SHALL hold and WB <= bubble; MemStall dominates LoadUse.
REQ-026 The next State SHALL be MEMWAIT if MemStall, else LOADUSE if LoadUse, else RUN; all transitions between the three states are legal.
REQ-027 StallCycles SHALL increment by 1 on each cycle with Stall=1 and saturate at 2^CNT_W-1 without wrapping.
REQ-028 A load in MEM matching a source with MemReady=1 SHALL yield FwdSel=2 and no stall.
REQ-029 Register 0 SHALL never cause a stall or a forward.

Reset
REQ-030 While RESET=0, the block SHALL asynchronously clear all stage valids, WbValid=0, WbDest=0, State=RUN and StallCycles=0.
REQ-031 Reset asserted mid-stall SHALL drop Stall to 0 immediately, because all stage valids clear; in-flight tags SHALL be discarded.
REQ-032 The first edge after RESET rises SHALL behave as a normal RUN cycle.

Verification
REQ-033 Scenario: issue add $3 (writes), then sub reading $3 on the next cycle -> FwdSel1=1, Stall=0.
REQ-034 Scenario: lw $5, then add reading $5 as Rt on the next cycle with MemReady=1 -> Stall=1 for one cycle, State=LOADUSE, then FwdSel2=2, Stall=0, StallCycles=1.
REQ-035 Scenario: lw $7 reaches MEM with MemReady held 0 for 3 cycles -> Stall=1 for 3 cycles, State=MEMWAIT, EX/MEM frozen, WbValid=0, StallCycles=3.
REQ-036 Scenario: $2 written in both EX and MEM, next instruction reads $2 -> FwdSel1=1 (EX priority).
REQ-037 Scenario: instruction writing $0 followed by a reader of $0 -> FwdSel=0, Stall=0.
REQ-038 Scenario: RESET pulled low during MEMWAIT -> Stall=0, State=RUN and StallCycles=0 before the next CLK edge.
